// File: rtl/seq_control.sv
// rtl/seq_control.sv - LEGv8 decode and multi-cycle sequencer; optional macro CONTROL_MEM_HANDSHAKE_EN
module seq_control #(
  parameter int MULT_TIMEOUT = 64,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        stall,
  input  logic        multiplier_done,
  input  logic        mem_ready,
  output logic        readreg2_loc,
  output logic        write_reg_src,
  output logic        reg_write,
  output logic        alu_src,
  output logic        execute_result_loc,
  output logic        update_sreg,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  alu_op,
  output logic        mult_start,
  output logic [1:0]  mult_mode,
  output logic [2:0]  branch_op,
  output logic [1:0]  mem_to_reg,
  output logic        busy,
  output logic        op_error
);

  localparam logic [2:0] BCOND_OP_NONE   = 3'd0;
  localparam logic [2:0] BCOND_OP_BRANCH = 3'd1;
  localparam logic [2:0] BCOND_OP_COND   = 3'd2;
  localparam logic [2:0] BCOND_OP_ZERO   = 3'd3;
  localparam logic [2:0] BCOND_OP_NZERO  = 3'd4;
  localparam logic [2:0] BCOND_OP_ALU    = 3'd5;
  localparam logic [2:0] BCOND_OP_NOINC  = 3'd6;

  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_LSL    = 4'b1000;
  localparam logic [3:0] ALU_LSR    = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  // Last count before abort, and the saturation ceiling of the 8-bit counter
  localparam logic [7:0] MULT_LAST = 8'(MULT_TIMEOUT - 1);
  localparam logic [7:0] MULT_MAX  = 8'(MULT_TIMEOUT);
  localparam logic [7:0] MEM_LAST  = 8'(MEM_TIMEOUT - 1);
  localparam logic [7:0] MEM_MAX   = 8'(MEM_TIMEOUT);

  typedef enum logic [4:0] {
    C_NONE, C_RTYPE, C_SHIFT, C_RTYPE_S, C_ITYPE, C_ITYPE_S, C_CMP, C_CMPI,
    C_CBZ, C_CBNZ, C_B, C_BCOND, C_BL, C_BR, C_MOV, C_MOVZ, C_MOVK, C_LDA,
    C_LOAD, C_STORE, C_MUL
  } op_class_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_WAIT
`ifdef CONTROL_MEM_HANDSHAKE_EN
    , S_MEM_WAIT
`endif
  } state_t;

  function automatic op_class_t classify(input logic [10:0] op);
    casez (op)
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: return C_RTYPE;
      11'b11010011011, 11'b11010011010: return C_SHIFT;
      11'b10101011000, 11'b11101011000,
      11'b11101010000:                  return C_RTYPE_S;
      11'b1001000100?, 11'b1001001000?, 11'b1101001000?,
      11'b1011001000?, 11'b1101000100?: return C_ITYPE;
      11'b1011000100?, 11'b1111001000?,
      11'b1111000100?:                  return C_ITYPE_S;
      11'b11101011001:                  return C_CMP;
      11'b11110011000:                  return C_CMPI;
      11'b10110100???:                  return C_CBZ;
      11'b10110101???:                  return C_CBNZ;
      11'b000101?????:                  return C_B;
      11'b01010100???:                  return C_BCOND;
      11'b100101?????:                  return C_BL;
      11'b11010110000:                  return C_BR;
      11'b10100010000:                  return C_MOV;
      11'b110100101??:                  return C_MOVZ;
      11'b111100101??:                  return C_MOVK;
      11'b10010001100:                  return C_LDA;
      11'b11111000010:                  return C_LOAD;
      11'b11111000000:                  return C_STORE;
      11'b10011011000, 11'b10011011110,
      11'b10011011010:                  return C_MUL;
      default:                          return C_NONE;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [10:0] op_q, op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_seen_q, done_seen_d;

  logic [10:0] dec_op;
  op_class_t   cls;
  logic        done_any;

  // While a multi-cycle op is in flight, decode from the captured opcode, not the live one
  assign dec_op   = (state_q == S_IDLE) ? opcode : op_q;
  assign cls      = classify(dec_op);
  assign done_any = multiplier_done | done_seen_q;

`ifndef CONTROL_MEM_HANDSHAKE_EN
  logic [16:0] mem_unused;
  assign mem_unused = {mem_ready, MEM_LAST, MEM_MAX};
`endif

  // Opcode decode, then FSM sequencing overrides, then the stall/reset blanking
  always_comb begin
    readreg2_loc       = 1'b0;
    write_reg_src      = 1'b0;
    reg_write          = 1'b0;
    alu_src            = 1'b0;
    execute_result_loc = 1'b0;
    update_sreg        = 1'b0;
    mem_read           = 1'b0;
    mem_write          = 1'b0;
    alu_op             = {1'b0, dec_op[9], dec_op[3], dec_op[8]};
    mult_start         = 1'b0;
    mult_mode          = 2'b00;
    branch_op          = BCOND_OP_NONE;
    mem_to_reg         = 2'b00;
    busy               = (state_q != S_IDLE);
    op_error           = 1'b0;
    state_d            = state_q;
    op_d               = op_q;
    cnt_d              = cnt_q;
    done_seen_d        = done_seen_q;

    case (cls)
      C_RTYPE:   reg_write = 1'b1;
      C_SHIFT: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = dec_op[0] ? ALU_LSL : ALU_LSR;
      end
      C_RTYPE_S: begin
        reg_write   = 1'b1;
        update_sreg = 1'b1;
      end
      C_ITYPE, C_MOVZ: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      C_ITYPE_S: begin
        reg_write   = 1'b1;
        alu_src     = 1'b1;
        update_sreg = 1'b1;
      end
      C_CMP:     update_sreg = 1'b1;
      C_CMPI: begin
        alu_src     = 1'b1;
        update_sreg = 1'b1;
      end
      C_CBZ, C_CBNZ: begin
        readreg2_loc = 1'b1;
        update_sreg  = 1'b1;
        branch_op    = (cls == C_CBZ) ? BCOND_OP_ZERO : BCOND_OP_NZERO;
        alu_op       = ALU_PASS_B;
      end
      C_B: begin
        branch_op = BCOND_OP_BRANCH;
        alu_op    = ALU_PASS_B;
      end
      C_BCOND: begin
        branch_op = BCOND_OP_COND;
        alu_op    = ALU_PASS_B;
      end
      C_BL: begin
        reg_write     = 1'b1;
        write_reg_src = 1'b1;
        branch_op     = BCOND_OP_BRANCH;
        mem_to_reg    = 2'b10;
        alu_op        = ALU_PASS_B;
      end
      C_BR: begin
        readreg2_loc = 1'b1;
        branch_op    = BCOND_OP_ALU;
        alu_op       = ALU_PASS_B;
      end
      C_MOV: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALU_ADD;
      end
      C_MOVK: begin
        readreg2_loc = 1'b1;
        reg_write    = 1'b1;
        alu_src      = 1'b1;
      end
      C_LDA: begin
        readreg2_loc = 1'b1;
        reg_write    = 1'b1;
        alu_src      = 1'b1;
        alu_op       = ALU_ADD;
      end
      C_LOAD: begin
        mem_read   = 1'b1;
        alu_src    = 1'b1;
        mem_to_reg = 2'b01;
        reg_write  = 1'b1;
        alu_op     = ALU_ADD;
      end
      C_STORE: begin
        readreg2_loc = 1'b1;
        alu_src      = 1'b1;
        mem_write    = 1'b1;
        alu_op       = ALU_ADD;
      end
      C_MUL: begin
        case (dec_op[2:1])
          2'b11:   mult_mode = 2'b01;
          2'b01:   mult_mode = 2'b10;
          default: mult_mode = 2'b00;
        endcase
      end
      default:   alu_op = 4'b0000;
    endcase

    case (state_q)
      S_IDLE: begin
        if (!stall && cls == C_MUL) begin
          mult_start  = 1'b1;
          branch_op   = BCOND_OP_NOINC;
          op_d        = opcode;
          cnt_d       = 8'd0;
          done_seen_d = 1'b0;
          state_d     = S_MUL_WAIT;
        end
`ifdef CONTROL_MEM_HANDSHAKE_EN
        else if (!stall && (cls == C_LOAD || cls == C_STORE) && !mem_ready) begin
          reg_write = 1'b0;
          branch_op = BCOND_OP_NOINC;
          op_d      = opcode;
          cnt_d     = 8'd0;
          state_d   = S_MEM_WAIT;
        end
`endif
      end
      S_MUL_WAIT: begin
        branch_op   = BCOND_OP_NOINC;
        done_seen_d = done_any;
        if (done_any && !stall) begin
          reg_write          = 1'b1;
          execute_result_loc = 1'b1;
          branch_op          = BCOND_OP_NONE;
          state_d            = S_IDLE;
        end else if (!done_any && cnt_q >= MULT_LAST) begin
          op_error  = 1'b1;
          branch_op = BCOND_OP_NONE;
          state_d   = S_IDLE;
        end else if (cnt_q != MULT_MAX) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef CONTROL_MEM_HANDSHAKE_EN
      S_MEM_WAIT: begin
        branch_op = BCOND_OP_NOINC;
        reg_write = 1'b0;
        if (mem_ready) begin
          reg_write = (cls == C_LOAD);
          branch_op = BCOND_OP_NONE;
          state_d   = S_IDLE;
        end else if (cnt_q >= MEM_LAST) begin
          op_error  = 1'b1;
          branch_op = BCOND_OP_NONE;
          state_d   = S_IDLE;
        end else if (cnt_q != MEM_MAX) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (reset || (state_q == S_IDLE && stall)) begin
      readreg2_loc       = 1'b0;
      write_reg_src      = 1'b0;
      reg_write          = 1'b0;
      alu_src            = 1'b0;
      execute_result_loc = 1'b0;
      update_sreg        = 1'b0;
      mem_read           = 1'b0;
      mem_write          = 1'b0;
      alu_op             = 4'b0000;
      mult_start         = 1'b0;
      mult_mode          = 2'b00;
      branch_op          = BCOND_OP_NOINC;
      mem_to_reg         = 2'b00;
      busy               = 1'b0;
      op_error           = 1'b0;
    end
  end

  // State, captured opcode, timeout counter and sticky done flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 11'd0;
      cnt_q       <= 8'd0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      done_seen_q <= done_seen_d;
    end
  end

endmodule

// File: tb/tb_seq_control.sv
// tb/tb_seq_control.sv - directed vector bench for seq_control
module tb_seq_control;

  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_LSL = 4'b1000;
  localparam logic [3:0] A_LSR = 4'b1001;
  localparam logic [3:0] A_PB  = 4'b1111;
  localparam logic [3:0] A_0   = 4'b0000;

  localparam logic [2:0] B_NONE = 3'd0;
  localparam logic [2:0] B_BR   = 3'd1;
  localparam logic [2:0] B_COND = 3'd2;
  localparam logic [2:0] B_ZERO = 3'd3;
  localparam logic [2:0] B_NZ   = 3'd4;
  localparam logic [2:0] B_ALU  = 3'd5;
  localparam logic [2:0] B_HOLD = 3'd6;

  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_LSL   = 11'b11010011011;
  localparam logic [10:0] OP_LSR   = 11'b11010011010;
  localparam logic [10:0] OP_ADDI  = 11'b10010001000;
  localparam logic [10:0] OP_ANDIS = 11'b11110010000;
  localparam logic [10:0] OP_CMP   = 11'b11101011001;
  localparam logic [10:0] OP_CMPI  = 11'b11110011000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100101;
  localparam logic [10:0] OP_CBNZ  = 11'b10110101000;
  localparam logic [10:0] OP_B     = 11'b00010100011;
  localparam logic [10:0] OP_BCOND = 11'b01010100000;
  localparam logic [10:0] OP_BL    = 11'b10010100000;
  localparam logic [10:0] OP_BRR   = 11'b11010110000;
  localparam logic [10:0] OP_MOV   = 11'b10100010000;
  localparam logic [10:0] OP_MOVZ  = 11'b11010010100;
  localparam logic [10:0] OP_MOVK  = 11'b11110010101;
  localparam logic [10:0] OP_LDA   = 11'b10010001100;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_MUL   = 11'b10011011000;
  localparam logic [10:0] OP_UMULH = 11'b10011011110;
  localparam logic [10:0] OP_SMULH = 11'b10011011010;
  localparam logic [10:0] OP_BAD   = 11'b00000000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] opcode = 11'd0;
  logic        stall = 1'b0;
  logic        multiplier_done = 1'b0;
  logic        mem_ready = 1'b0;
  logic        readreg2_loc, write_reg_src, reg_write, alu_src, execute_result_loc;
  logic        update_sreg, mem_read, mem_write, mult_start, busy, op_error;
  logic [3:0]  alu_op;
  logic [1:0]  mult_mode, mem_to_reg;
  logic [2:0]  branch_op;

  always #5 clk = ~clk;

  seq_control #(.MULT_TIMEOUT(8), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .stall(stall),
    .multiplier_done(multiplier_done), .mem_ready(mem_ready),
    .readreg2_loc(readreg2_loc), .write_reg_src(write_reg_src), .reg_write(reg_write),
    .alu_src(alu_src), .execute_result_loc(execute_result_loc), .update_sreg(update_sreg),
    .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op), .mult_start(mult_start),
    .mult_mode(mult_mode), .branch_op(branch_op), .mem_to_reg(mem_to_reg),
    .busy(busy), .op_error(op_error)
  );

  logic [21:0] act;
  assign act = {readreg2_loc, write_reg_src, reg_write, alu_src, execute_result_loc,
                update_sreg, mem_read, mem_write, alu_op, mult_start, mult_mode,
                branch_op, mem_to_reg, busy, op_error};

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [10:0] op;
    logic        st;
    logic        mrdy;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[27];

  // rr2 wrs rw as erl us mr mw alu ms mm bop m2r busy err
  function automatic logic [21:0] ex(input logic rr2, wrs, rw, as, erl, us, mr, mw,
                                     input logic [3:0] alu, input logic ms,
                                     input logic [1:0] mm, input logic [2:0] bop,
                                     input logic [1:0] m2r, input logic bsy, err);
    return {rr2, wrs, rw, as, erl, us, mr, mw, alu, ms, mm, bop, m2r, bsy, err};
  endfunction

  task automatic cyc(input logic [10:0] op, input logic st, dn, mrdy, rst,
                     input logic [21:0] exp, input string name);
    opcode          = op;
    stall           = st;
    multiplier_done = dn;
    mem_ready       = mrdy;
    reset           = rst;
    @(negedge clk);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [21:0] idle_add;
    logic [21:0] zero_none;
    idle_add  = ex(0,0,1,0,0,0,0,0,A_ADD,0,2'b00,B_NONE,2'b00,0,0);
    zero_none = ex(0,0,0,0,0,0,0,0,A_0,0,2'b00,B_NONE,2'b00,0,0);

    tbl[0]  = '{OP_ADDI,  1'b0, 1'b0, ex(0,0,1,1,0,0,0,0,A_ADD,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[1]  = '{OP_ADD,   1'b0, 1'b0, idle_add};
    tbl[2]  = '{OP_SUB,   1'b0, 1'b0, ex(0,0,1,0,0,0,0,0,4'b0110,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[3]  = '{OP_AND,   1'b0, 1'b0, ex(0,0,1,0,0,0,0,0,4'b0000,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[4]  = '{OP_ORR,   1'b0, 1'b0, ex(0,0,1,0,0,0,0,0,4'b0001,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[5]  = '{OP_SUBS,  1'b0, 1'b0, ex(0,0,1,0,0,1,0,0,4'b0111,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[6]  = '{OP_LSL,   1'b0, 1'b0, ex(0,0,1,1,0,0,0,0,A_LSL,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[7]  = '{OP_LSR,   1'b0, 1'b0, ex(0,0,1,1,0,0,0,0,A_LSR,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[8]  = '{OP_ANDIS, 1'b0, 1'b0, ex(0,0,1,1,0,1,0,0,4'b0101,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[9]  = '{OP_CMP,   1'b0, 1'b0, ex(0,0,0,0,0,1,0,0,4'b0111,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[10] = '{OP_CMPI,  1'b0, 1'b0, ex(0,0,0,1,0,1,0,0,4'b0111,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[11] = '{OP_CBZ,   1'b0, 1'b0, ex(1,0,0,0,0,1,0,0,A_PB,0,2'b00,B_ZERO,2'b00,0,0)};
    tbl[12] = '{OP_CBNZ,  1'b0, 1'b0, ex(1,0,0,0,0,1,0,0,A_PB,0,2'b00,B_NZ,2'b00,0,0)};
    tbl[13] = '{OP_B,     1'b0, 1'b0, ex(0,0,0,0,0,0,0,0,A_PB,0,2'b00,B_BR,2'b00,0,0)};
    tbl[14] = '{OP_BCOND, 1'b0, 1'b0, ex(0,0,0,0,0,0,0,0,A_PB,0,2'b00,B_COND,2'b00,0,0)};
    tbl[15] = '{OP_BL,    1'b0, 1'b0, ex(0,1,1,0,0,0,0,0,A_PB,0,2'b00,B_BR,2'b10,0,0)};
    tbl[16] = '{OP_BRR,   1'b0, 1'b0, ex(1,0,0,0,0,0,0,0,A_PB,0,2'b00,B_ALU,2'b00,0,0)};
    tbl[17] = '{OP_MOV,   1'b0, 1'b0, ex(0,0,1,1,0,0,0,0,A_ADD,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[18] = '{OP_MOVZ,  1'b0, 1'b0, ex(0,0,1,1,0,0,0,0,4'b0100,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[19] = '{OP_MOVK,  1'b0, 1'b0, ex(1,0,1,1,0,0,0,0,4'b0101,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[20] = '{OP_LDA,   1'b0, 1'b0, ex(1,0,1,1,0,0,0,0,A_ADD,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[21] = '{OP_STUR,  1'b0, 1'b1, ex(1,0,0,1,0,0,0,1,A_ADD,0,2'b00,B_NONE,2'b00,0,0)};
    tbl[22] = '{OP_LDUR,  1'b0, 1'b1, ex(0,0,1,1,0,0,1,0,A_ADD,0,2'b00,B_NONE,2'b01,0,0)};
    tbl[23] = '{OP_BAD,   1'b0, 1'b0, zero_none};
    tbl[24] = '{OP_ADD,   1'b1, 1'b0, ex(0,0,0,0,0,0,0,0,A_0,0,2'b00,B_HOLD,2'b00,0,0)};
    tbl[25] = '{OP_MUL,   1'b1, 1'b0, ex(0,0,0,0,0,0,0,0,A_0,0,2'b00,B_HOLD,2'b00,0,0)};
    tbl[26] = '{OP_ADD,   1'b0, 1'b0, idle_add};

    // Reset cycles: everything low except the PC hold
    cyc(OP_ADD, 0, 0, 0, 1, ex(0,0,0,0,0,0,0,0,A_0,0,2'b00,B_HOLD,2'b00,0,0), "reset0");
    cyc(OP_ADD, 0, 1, 1, 1, ex(0,0,0,0,0,0,0,0,A_0,0,2'b00,B_HOLD,2'b00,0,0), "reset1");

    for (int i = 0; i < 27; i++) begin
      opcode          = tbl[i].op;
      stall           = tbl[i].st;
      mem_ready       = tbl[i].mrdy;
      multiplier_done = 1'b0;
      reset           = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (act !== tbl[i].exp) begin
        n_bad++;
        $display("FAIL vec[%0d]: got %b want %b", i, act, tbl[i].exp);
      end
      @(posedge clk);
      #1;
    end

    // MUL, done on cycle 5; live opcode changes during the wait must be ignored
    cyc(OP_MUL, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,A_ADD,1,2'b00,B_HOLD,2'b00,0,0), "mul_c0");
    for (int i = 1; i < 5; i++)
      cyc(OP_BRR, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,A_ADD,0,2'b00,B_HOLD,2'b00,1,0), "mul_wait");
    cyc(OP_BRR, 0, 1, 0, 0, ex(0,0,1,0,1,0,0,0,A_ADD,0,2'b00,B_NONE,2'b00,1,0), "mul_wb");
    cyc(OP_ADD, 0, 0, 0, 0, idle_add, "mul_after");

    // SMULH: done arrives under stall, writeback on first unstalled cycle
    cyc(OP_SMULH, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,A_ADD,1,2'b10,B_HOLD,2'b00,0,0), "smulh_c0");
    cyc(OP_ADD, 1, 0, 0, 0, ex(0,0,0,0,0,0,0,0,A_ADD,0,2'b10,B_HOLD,2'b00,1,0), "smulh_c1");
    cyc(OP_ADD, 1, 1, 0, 0, ex(0,0,0,0,0,0,0,0,A_ADD,0,2'b10,B_HOLD,2'b00,1,0), "smulh_c2");
    cyc(OP_ADD, 1, 0, 0, 0, ex(0,0,0,0,0,0,0,0,A_ADD,0,2'b10,B_HOLD,2'b00,1,0), "smulh_c3");
    cyc(OP_ADD, 1, 0, 0, 0, ex(0,0,0,0,0,0,0,0,A_ADD,0,2'b10,B_HOLD,2'b00,1,0), "smulh_c4");
    cyc(OP_ADD, 0, 0, 0, 0, ex(0,0,1,0,1,0,0,0,A_ADD,0,2'b10,B_NONE,2'b00,1,0), "smulh_wb");
    cyc(OP_BAD, 0, 0, 0, 0, zero_none, "smulh_after");

    // UMULH with no done: abort on cycle 8
    cyc(OP_UMULH, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,A_ADD,1,2'b01,B_HOLD,2'b00,0,0), "umulh_c0");
    for (int i = 1; i < 8; i++)
      cyc(OP_ADD, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,A_ADD,0,2'b01,B_HOLD,2'b00,1,0), "umulh_wait");
    cyc(OP_ADD, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,A_ADD,0,2'b01,B_NONE,2'b00,1,1), "umulh_tmo");
    cyc(OP_BAD, 0, 0, 0, 0, zero_none, "umulh_after");

    // UMULH with done exactly on the timeout cycle: done wins
    cyc(OP_UMULH, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,A_ADD,1,2'b01,B_HOLD,2'b00,0,0), "race_c0");
    for (int i = 1; i < 8; i++)
      cyc(OP_ADD, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,A_ADD,0,2'b01,B_HOLD,2'b00,1,0), "race_wait");
    cyc(OP_ADD, 0, 1, 0, 0, ex(0,0,1,0,1,0,0,0,A_ADD,0,2'b01,B_NONE,2'b00,1,0), "race_wb");
    cyc(OP_ADD, 0, 0, 0, 0, idle_add, "race_after");

    // Reset in MUL_WAIT cycle 2 aborts silently
    cyc(OP_MUL, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,A_ADD,1,2'b00,B_HOLD,2'b00,0,0), "rst_c0");
    cyc(OP_ADD, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,A_ADD,0,2'b00,B_HOLD,2'b00,1,0), "rst_c1");
    cyc(OP_ADD, 0, 1, 0, 1, ex(0,0,0,0,0,0,0,0,A_0,0,2'b00,B_HOLD,2'b00,0,0), "rst_c2");
    cyc(OP_ADD, 0, 0, 0, 0, idle_add, "rst_c3");
    cyc(OP_ADD, 0, 1, 0, 0, idle_add, "rst_c4");

`ifdef CONTROL_MEM_HANDSHAKE_EN
    // LDUR with ready on cycle 3
    cyc(OP_LDUR, 0, 0, 0, 0, ex(0,0,0,1,0,0,1,0,A_ADD,0,2'b00,B_HOLD,2'b01,0,0), "ldur_c0");
    cyc(OP_ADD, 1, 0, 0, 0, ex(0,0,0,1,0,0,1,0,A_ADD,0,2'b00,B_HOLD,2'b01,1,0), "ldur_c1");
    cyc(OP_ADD, 0, 0, 0, 0, ex(0,0,0,1,0,0,1,0,A_ADD,0,2'b00,B_HOLD,2'b01,1,0), "ldur_c2");
    cyc(OP_ADD, 0, 0, 1, 0, ex(0,0,1,1,0,0,1,0,A_ADD,0,2'b00,B_NONE,2'b01,1,0), "ldur_c3");
    cyc(OP_ADD, 0, 0, 0, 0, idle_add, "ldur_after");
    // STUR with no ready: abort after MEM_TIMEOUT
    cyc(OP_STUR, 0, 0, 0, 0, ex(1,0,0,1,0,0,0,1,A_ADD,0,2'b00,B_HOLD,2'b00,0,0), "stur_c0");
    for (int i = 1; i < 4; i++)
      cyc(OP_ADD, 0, 0, 0, 0, ex(1,0,0,1,0,0,0,1,A_ADD,0,2'b00,B_HOLD,2'b00,1,0), "stur_wait");
    cyc(OP_ADD, 0, 0, 0, 0, ex(1,0,0,1,0,0,0,1,A_ADD,0,2'b00,B_NONE,2'b00,1,1), "stur_tmo");
    cyc(OP_ADD, 0, 0, 0, 0, idle_add, "stur_after");
`else
    // Without the handshake, memory ops complete in the decode cycle regardless of mem_ready
    cyc(OP_LDUR, 0, 0, 0, 0, ex(0,0,1,1,0,0,1,0,A_ADD,0,2'b00,B_NONE,2'b01,0,0), "ldur_c0");
    cyc(OP_STUR, 0, 0, 0, 0, ex(1,0,0,1,0,0,0,1,A_ADD,0,2'b00,B_NONE,2'b00,0,0), "stur_c0");
    cyc(OP_ADD, 0, 0, 0, 0, idle_add, "mem_after");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
